// File: rtl/uart_bus_ctrl.sv
// Bus-facing register block for the UART rx/tx engines: one-byte rx and tx
// buffers, tx start handshake FSM with timeout, sticky error flags and irq.
module uart_bus_ctrl #(
  parameter int DATA_W        = 32,
  parameter int START_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [1:0]        bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  input  logic              rx_done,
  input  logic [7:0]        rx_byte,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  output logic              irq
);

  typedef enum logic [1:0] {IDLE, START, SEND} state_t;

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              tx_start_next;
  logic [7:0]        tx_byte_next;
  logic              load, fault_set;

  logic [7:0]        rx_buf_reg, tx_buf_reg;
  logic              rx_valid_reg, rx_ovr_reg, tx_full_reg, tx_ovf_reg, tx_fault_reg;
  logic              rx_ie_reg, tx_ie_reg;

  logic              rd, wr_tx, wr_ctrl, rd_rx, rd_st, tx_accept;
  logic [4:0]        status;
  logic [DATA_W-1:0] rdata_next;

  // Only the low byte of the write bus carries data.
  logic unused_wdata;
  assign unused_wdata = ^bus_wdata[DATA_W-1:8];

  // A simultaneous write suppresses the read entirely.
  assign rd      = bus_re & ~bus_we;
  assign wr_tx   = bus_we & (bus_addr == 2'd0);
  assign wr_ctrl = bus_we & (bus_addr == 2'd3);
  assign rd_rx   = rd & (bus_addr == 2'd1);
  assign rd_st   = rd & (bus_addr == 2'd2);

  assign status = {tx_fault_reg, tx_ovf_reg, rx_ovr_reg,
                   tx_full_reg | (state_reg != IDLE), rx_valid_reg};

  always_comb begin
    rdata_next = bus_rdata;
    if (rd) begin
      case (bus_addr)
        2'd0:    rdata_next = '0;
        2'd1:    rdata_next = DATA_W'(rx_buf_reg);
        2'd2:    rdata_next = DATA_W'(status);
        default: rdata_next = DATA_W'({tx_ie_reg, rx_ie_reg});
      endcase
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    tx_start_next = 1'b0;
    tx_byte_next  = tx_byte;
    load          = 1'b0;
    fault_set     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tx_full_reg) begin
          load          = 1'b1;
          tx_byte_next  = tx_buf_reg;
          tx_start_next = 1'b1;
          cnt_next      = '0;
          state_next    = START;
        end
      end
      START: begin
        if (tx_busy) begin
          state_next = SEND;
        end else if (cnt_reg == CNT_W'(START_TIMEOUT - 1)) begin
          fault_set  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SEND: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The buffer frees up on the same edge it is handed to the engine, so a
  // write on that edge is accepted rather than flagged as overflow.
  assign tx_accept = wr_tx & (~tx_full_reg | load);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      tx_start     <= 1'b0;
      tx_byte      <= '0;
      bus_rdata    <= '0;
      irq          <= 1'b0;
      rx_buf_reg   <= '0;
      tx_buf_reg   <= '0;
      rx_valid_reg <= 1'b0;
      rx_ovr_reg   <= 1'b0;
      tx_full_reg  <= 1'b0;
      tx_ovf_reg   <= 1'b0;
      tx_fault_reg <= 1'b0;
      rx_ie_reg    <= 1'b0;
      tx_ie_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      tx_start  <= tx_start_next;
      tx_byte   <= tx_byte_next;
      bus_rdata <= rdata_next;

      if (wr_ctrl) {tx_ie_reg, rx_ie_reg} <= bus_wdata[1:0];

      if (tx_accept) begin
        tx_buf_reg  <= bus_wdata[7:0];
        tx_full_reg <= 1'b1;
      end else if (load) begin
        tx_full_reg <= 1'b0;
      end

      if (rx_done) begin
        rx_buf_reg   <= rx_byte;
        rx_valid_reg <= 1'b1;
      end else if (rd_rx) begin
        rx_valid_reg <= 1'b0;
      end

      // Sticky flags: a new set on the same edge as a STATUS read wins.
      if (rx_done & rx_valid_reg & ~rd_rx) rx_ovr_reg <= 1'b1;
      else if (rd_st)                      rx_ovr_reg <= 1'b0;

      if (wr_tx & ~tx_accept) tx_ovf_reg <= 1'b1;
      else if (rd_st)         tx_ovf_reg <= 1'b0;

      if (fault_set)  tx_fault_reg <= 1'b1;
      else if (rd_st) tx_fault_reg <= 1'b0;

      irq <= (rx_ie_reg & rx_valid_reg)
           | (tx_ie_reg & ~tx_full_reg & (state_reg == IDLE))
           | rx_ovr_reg | tx_ovf_reg | tx_fault_reg;
    end
  end

endmodule
